// File: rtl/ber_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ber_test_ctrl
// Brief    : BER tester sequencer. Resets and enables the PRBS generator,
//            waits for checker lock, then measures a programmed number of
//            words while accumulating a saturating bit-error count.
//            Optional pause input is built when BER_CTRL_PAUSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ber_test_ctrl #(
  parameter int INIT_CYCLES  = 4,     // generator reset hold after start (>=1)
  parameter int LOCK_TIMEOUT = 1024,  // SYNC cycles allowed before timeout (>=1)
  parameter int CNT_W        = 32     // counter width (>=4)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] test_len,
  output logic             gen_reset,
  output logic             gen_en,
  input  logic             chk_locked,
  input  logic             err_valid,
  input  logic [3:0]       err_bits,
`ifdef BER_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sat
);

  // Shared cycle counter covers both the INIT hold and the SYNC timeout.
  localparam int c_cyc_max = (INIT_CYCLES > LOCK_TIMEOUT) ? INIT_CYCLES : LOCK_TIMEOUT;
  localparam int c_cyc_w   = (c_cyc_max > 1) ? $clog2(c_cyc_max + 1) : 1;

  localparam logic [c_cyc_w-1:0] c_init_load = c_cyc_w'(INIT_CYCLES - 1);
  localparam logic [c_cyc_w-1:0] c_lock_load = c_cyc_w'(LOCK_TIMEOUT - 1);
  localparam logic [c_cyc_w-1:0] c_cyc_one   = c_cyc_w'(1);
  localparam logic [CNT_W-1:0]   c_cnt_one   = CNT_W'(1);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_init = 3'd1;
  localparam logic [2:0] c_st_sync = 3'd2;
  localparam logic [2:0] c_st_run  = 3'd3;
  localparam logic [2:0] c_st_done = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_cyc_w-1:0] r_cyc_cnt;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_word_cnt;
  logic [CNT_W-1:0]   r_err_cnt;
  logic               r_err_sat;
  logic               r_timeout;
  logic               r_gen_reset;
  logic               r_gen_en;
  logic               r_busy;
  logic               r_done;

  logic               w_pause;
  logic               w_start_acc;
  logic               w_sync_to;
  logic               w_word_inc;
  logic [CNT_W-1:0]   w_word_nxt;
  logic [3:0]         w_err_clamp;
  logic [CNT_W:0]     w_err_sum;
  logic               w_gen_reset_nxt;
  logic               w_gen_en_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

`ifdef BER_CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // A word never carries more than 8 bit errors; larger reports are clamped.
  assign w_err_clamp = (err_bits > 4'd8) ? 4'd8 : err_bits;
  assign w_err_sum   = {1'b0, r_err_cnt} + {{(CNT_W-3){1'b0}}, w_err_clamp};
  assign w_word_nxt  = r_word_cnt + c_cnt_one;

  // State register plus outputs registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_st_idle;
      r_gen_reset <= 1'b1;
      r_gen_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gen_reset <= w_gen_reset_nxt;
      r_gen_en    <= w_gen_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state decode; abort overrides everything, including start.
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_sync_to   = 1'b0;
    w_word_inc  = 1'b0;
    if (abort) begin
      w_state_nxt = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle, c_st_done: begin
          if (start) begin
            w_state_nxt = c_st_init;
            w_start_acc = 1'b1;
          end
        end
        c_st_init: begin
          if (r_cyc_cnt == '0) begin
            w_state_nxt = c_st_sync;
          end
        end
        c_st_sync: begin
          // Lock seen on the final timeout cycle still counts as lock.
          if (chk_locked) begin
            w_state_nxt = c_st_run;
          end else if (!w_pause && (r_cyc_cnt == '0)) begin
            w_state_nxt = c_st_idle;
            w_sync_to   = 1'b1;
          end
        end
        c_st_run: begin
          if (err_valid && !w_pause) begin
            w_word_inc = 1'b1;
            if (w_word_nxt == r_len) begin
              w_state_nxt = c_st_done;
            end
          end
        end
        default: begin
          w_state_nxt = c_st_idle;
        end
      endcase
    end
  end

  // Output decode from the next state so outputs move with the transition.
  always_comb begin
    w_gen_reset_nxt = 1'b1;
    w_gen_en_nxt    = 1'b0;
    w_busy_nxt      = 1'b0;
    w_done_nxt      = 1'b0;
    case (w_state_nxt)
      c_st_init: begin
        w_busy_nxt = 1'b1;
      end
      c_st_sync, c_st_run: begin
        w_gen_reset_nxt = 1'b0;
        w_gen_en_nxt    = !w_pause;
        w_busy_nxt      = 1'b1;
      end
      c_st_done: begin
        // Generator is neither reset nor clocked, so its state is held.
        w_gen_reset_nxt = 1'b0;
        w_done_nxt      = 1'b1;
      end
      default: begin
        w_gen_reset_nxt = 1'b1;
      end
    endcase
  end

  // Cycle counter: INIT hold length, then SYNC lock-wait budget.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc_cnt <= '0;
    end else if (w_start_acc) begin
      r_cyc_cnt <= c_init_load;
    end else if (r_state == c_st_init) begin
      r_cyc_cnt <= (r_cyc_cnt == '0) ? c_lock_load : (r_cyc_cnt - c_cyc_one);
    end else if ((r_state == c_st_sync) && !w_pause && (r_cyc_cnt != '0)) begin
      r_cyc_cnt <= r_cyc_cnt - c_cyc_one;
    end
  end

  // Measurement counters and sticky flags; abort leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len      <= c_cnt_one;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_sat  <= 1'b0;
      r_timeout  <= 1'b0;
    end else if (w_start_acc) begin
      r_len      <= (test_len == '0) ? c_cnt_one : test_len;
      r_word_cnt <= '0;
      r_err_cnt  <= '0;
      r_err_sat  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_sync_to) begin
        r_timeout <= 1'b1;
      end
      if (w_word_inc) begin
        r_word_cnt <= w_word_nxt;
        if (w_err_sum[CNT_W] || (&w_err_sum[CNT_W-1:0])) begin
          r_err_cnt <= '1;
          r_err_sat <= 1'b1;
        end else begin
          r_err_cnt <= w_err_sum[CNT_W-1:0];
        end
      end
    end
  end

  assign gen_reset = r_gen_reset;
  assign gen_en    = r_gen_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign word_cnt  = r_word_cnt;
  assign err_cnt   = r_err_cnt;
  assign err_sat   = r_err_sat;

endmodule
`default_nettype wire
